traffic_timer: RTL and testbench

TRAFFIC_TIMER -- requirements
Module: traffic_timer

---
 rtl/traffic_timer.sv | 91 +++++++++
 tb/tb_traffic_timer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/traffic_timer.sv
// traffic_timer: prescaled tick generator plus three saturating phase counters
// (Red/Yellow/Green) with terminal-count flags, remaining-ticks and a sticky overlap error.
`default_nettype none

module traffic_timer #(
  parameter int PRESCALE    = 4,
  parameter int RED_TERM    = 2,
  parameter int YELLOW_TERM = 1,
  parameter int GREEN_TERM  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Red_count_clear,
  input  logic       Yellow_count_clear,
  input  logic       Green_count_clear,
  output logic       Red_count_eql2,
  output logic       Yellow_count_eql1,
  output logic       Green_count_eql4,
  output logic       tick,
  output logic [3:0] remain,
  output logic       phase_err
);

  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [3:0]      TERM [3] = '{4'(RED_TERM), 4'(YELLOW_TERM), 4'(GREEN_TERM)};

  logic [PW-1:0] pre;
  logic [3:0]    cnt [3];
  logic [2:0]    clr;
  logic [2:0]    eql;
  logic          overlap;

  // bit 0 = Red, bit 1 = Yellow, bit 2 = Green throughout
  assign clr = {Green_count_clear, Yellow_count_clear, Red_count_clear};

  // Two or more clears low at once means two phases claim the light
  assign overlap = (~clr[0] & ~clr[1]) | (~clr[0] & ~clr[2]) | (~clr[1] & ~clr[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pre == PRE_MAX);
      pre  <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
    end
  end

  // Clear has priority over tick; counters saturate at their terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clr[i])
          cnt[i] <= 4'd0;
        else if (tick && (cnt[i] < TERM[i]))
          cnt[i] <= cnt[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase_err <= 1'b0;
    else if (overlap)
      phase_err <= 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) eql[i] = (cnt[i] == TERM[i]) && !clr[i];
  end

  assign Red_count_eql2    = eql[0];
  assign Yellow_count_eql1 = eql[1];
  assign Green_count_eql4  = eql[2];

  always_comb begin
    remain = 4'd0;
    case (clr)
      3'b110:  remain = TERM[0] - cnt[0];
      3'b101:  remain = TERM[1] - cnt[1];
      3'b011:  remain = TERM[2] - cnt[2];
      default: remain = 4'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_traffic_timer.sv
// Scoreboard bench for traffic_timer: a cycle-level behavioural model queues expected
// outputs per cycle; a negedge monitor pops and compares them against the DUT.
`default_nettype none

module tb_traffic_timer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  bit   [2:0] clr = 3'b111;
  logic       Red_count_eql2, Yellow_count_eql1, Green_count_eql4, tick, phase_err;
  logic [3:0] remain;
  logic       Red_count_clear, Yellow_count_clear, Green_count_clear;

  assign Red_count_clear    = clr[0];
  assign Yellow_count_clear = clr[1];
  assign Green_count_clear  = clr[2];

  traffic_timer #(.PRESCALE(P), .RED_TERM(2), .YELLOW_TERM(1), .GREEN_TERM(4)) dut (
    .clk(clk), .rst(rst),
    .Red_count_clear(Red_count_clear), .Yellow_count_clear(Yellow_count_clear),
    .Green_count_clear(Green_count_clear),
    .Red_count_eql2(Red_count_eql2), .Yellow_count_eql1(Yellow_count_eql1),
    .Green_count_eql4(Green_count_eql4),
    .tick(tick), .remain(remain), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {tick, eqlG, eqlY, eqlR, remain[3:0], phase_err}
  logic [8:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: ticks counted in clock edges since reset release
  int mterm [3] = '{2, 1, 4};
  int mcnt  [3];
  int n;
  bit mtick, merr;

  function automatic int zeros(input bit [2:0] c);
    return (c[0] ? 0 : 1) + (c[1] ? 0 : 1) + (c[2] ? 0 : 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    n = 0; mtick = 0; merr = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clr[i]) mcnt[i] = 0;
        else if (mtick && mcnt[i] < mterm[i]) mcnt[i] = mcnt[i] + 1;
      end
      if (zeros(clr) >= 2) merr = 1;
      n = n + 1;
      mtick = (n % P == 0);
    end
  endtask

  function automatic logic [8:0] expected();
    logic [2:0] e;
    int rem;
    rem = 0;
    for (int i = 0; i < 3; i++) begin
      e[i] = !clr[i] && (mcnt[i] == mterm[i]);
      if (zeros(clr) == 1 && !clr[i]) rem = mterm[i] - mcnt[i];
    end
    return {mtick, e[2], e[1], e[0], 4'(rem), merr};
  endfunction

  int ph_idx = 0;
  bit [2:0] ph_list [4] = '{3'b110, 3'b101, 3'b011, 3'b101};
  int ph_act [4] = '{0, 1, 2, 1};

  task automatic do_step(input bit ctrl, input bit [2:0] c, input bit rst_next);
    @(posedge clk);
    model_edge();
    if (ctrl) begin
      if (mcnt[ph_act[ph_idx]] == mterm[ph_act[ph_idx]] && !clr[ph_act[ph_idx]])
        ph_idx = (ph_idx + 1) % 4;
      c = ph_list[ph_idx];
    end
    #1;
    clr = c;
    rst = rst_next;
    if (rst_next) model_reset();
    exp_q.push_back(expected());
  endtask

  initial begin : monitor
    logic [8:0] e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {tick, Green_count_eql4, Yellow_count_eql1, Red_count_eql2, remain, phase_err};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t {tick,eqlG,eqlY,eqlR,remain,err} got=%b_%b_%b_%b_%0d_%b required=%b_%b_%b_%b_%0d_%b",
                   $time, got[8], got[7], got[6], got[5], got[4:1], got[0],
                   e[8], e[7], e[6], e[5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin : stimulus
    bit [2:0] c;
    int r, hold;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // idle: all clears high, only tick activity
    repeat (20) do_step(1'b0, 3'b111, 1'b0);

    // controller loop R2 Y1 G4 Y1 ...
    ph_idx = 0;
    repeat (120) do_step(1'b1, 3'b111, 1'b0);

    // reset mid-phase then restart
    do_step(1'b0, 3'b011, 1'b1);
    do_step(1'b0, 3'b011, 1'b0);
    repeat (20) do_step(1'b0, 3'b011, 1'b0);

    // randomized phases with occasional overlaps and async resets
    c = 3'b110;
    hold = 0;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      c = ~(3'b001 << $urandom_range(0, 2));
        else if (r <= 7) c = 3'b111;
        else             c = 3'($urandom_range(0, 7));
      end
      if (hold > 0) begin
        hold--;
        do_step(1'b0, c, hold > 0);
      end else if ($urandom_range(0, 299) == 0) begin
        hold = $urandom_range(1, 3);
        do_step(1'b0, c, 1'b1);
      end else begin
        do_step(1'b0, c, 1'b0);
      end
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
